memc_deskew: RTL
================

Name: memc_deskew

Overview:
- Output-side companion to the A/B skew buffers of the systolic array.
- The array emits result lanes time-skewed: lane j is valid j cycles after lane 0.
- This block de-skews those lanes into a DIM x DIM row buffer, flags completion, and serves registered row reads to the host/MMIO side.
- It is the reader/collector end of the same skewed-stream interface that the A-side feeder drives.

Parameters:
- BITS_C, 16, signed width of each result element.
- DIM, 8, array dimension (lanes per row, rows per tile).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin capture of a new tile (accepted only in IDLE or DONE).
- en  input  1  array advance strobe; one skew step per cycle with en=1.
- Cin  input  [DIM-1:0] x BITS_C signed  skewed result lanes from the array.
- rd_en  input  1  row read request.
- Crow  input  $clog2(DIM)  row index for read.
- Cout  output  [DIM-1:0] x BITS_C signed  registered read row.
- rd_valid  output  1  Cout holds data for the previous cycle's accepted read.
- busy  output  1  high in CAPTURE.
- done  output  1  high in DONE (full tile captured).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, step counter=0, buffer all zero.
  - Cout all zero, rd_valid=0, busy=0, done=0.
- States: IDLE, CAPTURE, DONE.
- Transitions:
  - IDLE --start--> CAPTURE.
  - CAPTURE --last step--> DONE.
  - DONE --start--> CAPTURE.
  - start while in CAPTURE is ignored.
- Entering CAPTURE:
  - counter cleared to 0, done cleared the same edge.
  - Buffer is not cleared; each entry is overwritten during capture.
- CAPTURE, each cycle with en=1:
  - For every lane j, with k = counter - j: if 0 <= k <= DIM-1, write buf[k][j] <= Cin[j]. Otherwise lane j is ignored this step.
  - counter <= counter + 1.
- CAPTURE with en=0: no writes, counter holds (stall). Stalls may be arbitrarily long.
- Last step: the en cycle with counter == 2*DIM-2.
  - Next state is DONE; done=1 and busy=0 from the following cycle.
  - Total of exactly 2*DIM-1 en cycles per tile.
- Counter width: $clog2(2*DIM) bits. No wrap is possible because capture ends at 2*DIM-2.
- Reads:
  - Accepted only in DONE with rd_en=1.
  - Cout <= buf[Crow] at that edge; rd_valid=1 the next cycle (1-cycle latency).
  - Back-to-back reads allowed, one row per cycle.
- rd_en outside DONE: rd_valid=0, Cout holds its last value.
- rd_en without a new accepted read: rd_valid=0 next cycle, Cout holds.
- Crow >= DIM (non-power-of-2 DIM): Cout <= all zero, rd_valid=1.
- start and rd_en in the same cycle in DONE:
  - start wins; the read is not accepted, rd_valid=0.
  - The state goes to CAPTURE.
- en outside CAPTURE: ignored. Cin is don't-care outside CAPTURE or when en=0.
- Arithmetic: pure storage, no sign extension or truncation; data stored bit-exact.
- Reset asserted mid-capture or mid-read: immediate return to the reset state above; the partial tile is discarded (buffer zeroed).

Test Plan:
- Basic tile (DIM=8, BITS_C=16):
  - Stimulus: pulse start, then 15 consecutive en cycles, driving lane j at step t with 16*(t-j)+j.
  - Required: done rises the cycle after the 15th en, busy falls the same cycle.
  - Read Crow=3 -> next cycle rd_valid=1, Cout={48,49,...,55}.
  - Read Crow=7 -> Cout={112,...,119}.
- Stalls:
  - Stimulus: same data as the basic tile, with en deasserted for 3 cycles after steps 2, 9 and 14.
  - Required: identical buffer contents to the basic tile; done only after the 15th en.
  - Garbage on Cin during stalls must not be stored.
- Skew boundaries:
  - Stimulus: drive lane 7 = 0x7FFF at steps 0-6 and lane 0 = 0x7FFF at steps 8-14; drive valid data in all in-window slots.
  - Required: no 0x7FFF appears in any row; row 0 lane 7 holds the step-7 value.
  - Negative value -5 on lane 2 at step 4 reads back as 0xFFFB in row 2 lane 2.
- Back-to-back reads and restart:
  - Stimulus: reads of rows 0..7 on 8 consecutive cycles.
  - Required: rd_valid high for 8 cycles with the matching rows.
  - Stimulus: start together with rd_en in DONE.
  - Required: rd_valid=0 next cycle, busy=1, done=0. A new tile then overwrites all rows.
- Illegal and ignored requests:
  - rd_en in IDLE and during CAPTURE -> rd_valid stays 0, Cout unchanged.
  - start mid-CAPTURE at step 5 -> ignored; done still after the 15th en.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously at step 6 of a capture.
  - Required: busy, done, rd_valid and Cout are 0 immediately.
  - After release, a read with no capture is ignored (IDLE).
  - A fresh full tile then reads back correctly.

Source files
------------

// File: rtl/memc_deskew_if.sv
// Skewed result stream from the systolic array plus the host row-read port.
// Latency: n/a (signal bundle only). Backpressure: none; en is the only pacing.
// master drives capture/read requests, slave returns rows and status.
interface memc_deskew_if #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8
);
    logic                          start;
    logic                          en;
    logic [DIM-1:0][BITS_C-1:0]    Cin;
    logic                          rd_en;
    logic [$clog2(DIM)-1:0]        Crow;
    logic [DIM-1:0][BITS_C-1:0]    Cout;
    logic                          rd_valid;
    logic                          busy;
    logic                          done;

    modport master (
        output start, en, Cin, rd_en, Crow,
        input  Cout, rd_valid, busy, done
    );

    modport slave (
        input  start, en, Cin, rd_en, Crow,
        output Cout, rd_valid, busy, done
    );
endinterface

// File: rtl/memc_deskew.sv
// De-skews time-staggered array result lanes into a DIM x DIM row buffer.
// Latency: row read returns 1 cycle after an accepted rd_en.
// Backpressure: none; en=0 stalls capture indefinitely, reads only in DONE.
module memc_deskew #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    memc_deskew_if.slave bus
);
    localparam int CW = $clog2(2*DIM);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CAP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                 r_state;
    logic [CW-1:0]              r_cnt;
    logic [BITS_C-1:0]          r_buf [DIM][DIM];
    logic [DIM-1:0][BITS_C-1:0] r_cout;
    logic                       r_rd_valid;

    logic w_start;
    logic w_step;
    logic w_last;
    logic w_rd;
    logic w_row_ok;

    assign w_start  = bus.start && (r_state != S_CAP);
    assign w_step   = (r_state == S_CAP) && bus.en;
    assign w_last   = w_step && (r_cnt == CW'(2*DIM-2));
    // start in DONE takes priority over a simultaneous read
    assign w_rd     = (r_state == S_DONE) && bus.rd_en && !bus.start;
    assign w_row_ok = (32'(bus.Crow) < 32'(DIM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (w_start) begin
            r_state <= S_CAP;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_state <= S_DONE;
            end
        end
    end

    // Lane j at step t carries row t-j; entries outside the window are skew padding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DIM; k++) begin
                for (int j = 0; j < DIM; j++) begin
                    r_buf[k][j] <= '0;
                end
            end
        end else if (w_step) begin
            for (int k = 0; k < DIM; k++) begin
                for (int j = 0; j < DIM; j++) begin
                    if (32'(r_cnt) == 32'(k + j)) begin
                        r_buf[k][j] <= bus.Cin[j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cout     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd;
            if (w_rd) begin
                for (int j = 0; j < DIM; j++) begin
                    r_cout[j] <= w_row_ok ? r_buf[bus.Crow][j] : '0;
                end
            end
        end
    end

    assign bus.Cout     = r_cout;
    assign bus.rd_valid = r_rd_valid;
    assign bus.busy     = (r_state == S_CAP);
    assign bus.done     = (r_state == S_DONE);
endmodule
